frame_assembler: RTL and testbench
==================================

FRAME_ASSEMBLER -- requirements
Module: frame_assembler

Interface
REQ-001 The block SHALL have parameter PARITY_EN, default 1, meaning a parity bit follows the data bits when 1 and is absent when 0.
REQ-002 The block SHALL have parameter PARITY_ODD, default 0, meaning 0 selects even parity and 1 selects odd parity.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port rx, input, 1 bit: serial data line.
REQ-006 The block SHALL have port bit_valid, input, 1 bit: rx is sampled only on edges where bit_valid=1.
REQ-007 The block SHALL have port in, output, 11 bits: last good frame, bits [10:8] field and [7:0] payload; drives the decoder's in.
REQ-008 The block SHALL have port enable, output, 1 bit: one-cycle strobe marking a new word on in; drives the decoder's enable.
REQ-009 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse for a rejected frame.
REQ-010 The block SHALL have port frame_cnt, output, 8 bits: count of good frames.

Function
REQ-011 The FSM SHALL have states IDLE, DATA, PARITY and STOP; with bit_valid=0 it holds state and every register except the strobes.
REQ-012 IDLE: bit_valid=1 with rx=0 (start bit) SHALL go to DATA with the bit counter cleared; bit_valid=1 with rx=1 SHALL stay IDLE.
REQ-013 DATA SHALL shift rx into an 11-bit shift register, MSB (bit 10) first, one bit per bit_valid.
REQ-014 DATA SHALL leave after the 11th bit, going to PARITY if PARITY_EN=1 and to STOP otherwise.
REQ-015 PARITY: on bit_valid, parity_ok SHALL be set to (rx == ^shift) for even parity or (rx == ~^shift) for odd; the FSM then goes to STOP.
REQ-016 STOP, frame good (bit_valid, rx=1, parity_ok or PARITY_EN=0) -> in SHALL load the shift register on that edge (edge N), and frame_cnt SHALL increment on edge N.
REQ-017 For a good frame, enable SHALL be high from edge N+1 to edge N+2 only, so in is stable one full cycle before enable rises.
REQ-018 STOP, frame bad (rx=0 or parity failed) -> frame_err SHALL pulse high for exactly one cycle after edge N, with in, enable and frame_cnt unchanged.
REQ-019 The FSM SHALL return to IDLE after every STOP sample, good or bad.
REQ-020 frame_cnt SHALL wrap from 255 to 0 without any flag.
REQ-021 in SHALL hold its value between good frames, and enable and frame_err SHALL never be high in the same cycle.
REQ-022 A start bit sampled in the cycle enable is high SHALL be accepted normally; back-to-back frames need no idle bit.

Reset
REQ-023 On rst=1, asynchronously, the FSM SHALL go to IDLE and in=0, enable=0, frame_err=0, frame_cnt=0, with the shift register, bit counter and parity_ok cleared.
REQ-024 Reset mid-frame SHALL discard the partial frame with no enable and no frame_err.
REQ-025 The first start bit SHALL be accepted on the first bit_valid edge after rst deasserts.

Structure
REQ-026 Shared package frame_pkg SHALL hold the FSM state enum, WORD_W=11, FIELD_W=3 and PAYLOAD_W=8; the decoder SHALL reuse the widths.
REQ-027 The block SHALL be a single module with no sub-module; parity SHALL be a reduction XOR inside it.

Verification
REQ-028 With even parity, bits 0,11100000000,1,1 -> in=11'h700, one enable pulse starting 1 cycle after the stop edge, frame_cnt=1, frame_err=0.
REQ-029 The same frame with parity bit 0 -> frame_err one cycle, in stays at its previous value, no enable, frame_cnt unchanged.
REQ-030 Frame 11'h0A5 with stop bit 0 -> frame_err, no enable.
REQ-031 Frame 11'h3FF with random 0-5 cycle bit_valid gaps between bits -> in=11'h3FF and exactly one enable.
REQ-032 rst pulsed after the 6th data bit, then a full frame 11'h123 -> only in=11'h123 appears, frame_cnt=1.
REQ-033 256 back-to-back good frames -> frame_cnt wraps to 0, 256 enable pulses, with PARITY_EN=0 rerun passing.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared widths and FSM state encoding for the serial frame assembler
// and the downstream decoder.
package frame_pkg;

  localparam int WORD_W    = 11;
  localparam int FIELD_W   = 3;
  localparam int PAYLOAD_W = 8;
  localparam int BCNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

endpackage

// File: rtl/frame_assembler.sv
// Serial frame assembler: start bit, 11 data bits MSB first,
// optional parity, stop bit; emits good words to the decoder.
module frame_assembler
  import frame_pkg::*;
#(
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic              bit_valid,
  output logic [WORD_W-1:0] in,
  output logic              enable,
  output logic              frame_err,
  output logic [7:0]        frame_cnt
);

  localparam logic [BCNT_W-1:0] LAST = BCNT_W'(WORD_W - 1);

  state_t              state;
  logic [WORD_W-1:0]   shift;
  logic [BCNT_W-1:0]   bcnt;
  logic                parity_ok;
  logic                good_q;
  logic                par_exp;
  logic                stop_good;

  assign par_exp   = PARITY_ODD ? ~^shift : ^shift;
  assign stop_good = rx && (parity_ok || !PARITY_EN);

  // enable lags the load of in by one cycle so in is settled first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift     <= '0;
      bcnt      <= '0;
      parity_ok <= 1'b0;
      good_q    <= 1'b0;
      in        <= '0;
      enable    <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      good_q    <= 1'b0;
      frame_err <= 1'b0;
      enable    <= good_q;
      if (bit_valid) begin
        unique case (state)
          IDLE: begin
            if (!rx) begin
              state <= DATA;
              bcnt  <= '0;
            end
          end
          DATA: begin
            shift <= {shift[WORD_W-2:0], rx};
            bcnt  <= bcnt + 1'b1;
            if (bcnt == LAST)
              state <= PARITY_EN ? PARITY : STOP;
          end
          PARITY: begin
            parity_ok <= (rx == par_exp);
            state     <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (stop_good) begin
              in        <= shift;
              frame_cnt <= frame_cnt + 8'd1;
              good_q    <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_assembler.sv
// Randomized scoreboard bench for frame_assembler, with and
// without the parity bit.
module tb_frame_assembler;

  typedef struct {
    bit          err;
    logic [10:0] word;
    logic [7:0]  cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  rxv = 2'b11;
  logic [1:0]  bvv = 2'b00;
  logic [10:0] inw [2];
  logic [1:0]  en;
  logic [1:0]  err;
  logic [7:0]  cntw [2];

  int n_chk = 0;
  int n_fail = 0;

  exp_t        q0 [$];
  exp_t        q1 [$];
  logic [10:0] mlast [2];
  logic [7:0]  mcnt [2];
  int          encnt [2];
  logic [10:0] prev_in [2];
  logic [1:0]  prev_en = 2'b00;
  logic [1:0]  prev_err = 2'b00;

  always #5 clk = ~clk;

  frame_assembler #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut0 (
    .clk(clk), .rst(rst), .rx(rxv[0]), .bit_valid(bvv[0]),
    .in(inw[0]), .enable(en[0]), .frame_err(err[0]),
    .frame_cnt(cntw[0])
  );

  frame_assembler #(.PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut1 (
    .clk(clk), .rst(rst), .rx(rxv[1]), .bit_valid(bvv[1]),
    .in(inw[1]), .enable(en[1]), .frame_err(err[1]),
    .frame_cnt(cntw[1])
  );

  task automatic chk(input string nm, input int k,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h, expected %0h at %0t",
               nm, k, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  // Monitor: pop one expectation per enable or frame_err pulse
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        if (en[k] || err[k]) begin
          exp_t e;
          chk("excl", k, {31'd0, en[k] & err[k]}, 0);
          if (qsize(k) == 0) begin
            chk("unexpected_out", k, 1, 0);
          end else begin
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
            chk("kind_err", k, {31'd0, err[k]}, {31'd0, e.err});
            chk("in", k, {21'd0, inw[k]}, {21'd0, e.word});
            chk("cnt", k, {24'd0, cntw[k]}, {24'd0, e.cnt});
            if (en[k]) begin
              encnt[k]++;
              chk("in_setup", k, {21'd0, prev_in[k]}, {21'd0, inw[k]});
              chk("en_width", k, {31'd0, prev_en[k]}, 0);
            end else begin
              chk("err_width", k, {31'd0, prev_err[k]}, 0);
            end
          end
        end
        prev_in[k] = inw[k];
      end
      prev_en = en;
      prev_err = err;
    end
  end

  task automatic send_bit(input int k, input bit b, input int gmax);
    repeat ($urandom_range(0, gmax)) begin
      @(negedge clk);
      bvv[k] = 1'b0;
    end
    @(negedge clk);
    rxv[k] = b;
    bvv[k] = 1'b1;
  endtask

  // Reference: parity bit makes total ones even; frame good when the
  // stop bit is 1 and the parity bit (if any) is right.
  task automatic send_frame(input int k, input logic [10:0] w,
                            input bit perr, input bit stopb,
                            input int gmax);
    bit   pen;
    bit   p;
    exp_t e;
    pen = (k == 0);
    p   = bit'($countones(w) % 2) ^ perr;
    e.err = !(stopb && (!pen || !perr));
    if (!e.err) begin
      mcnt[k]  = mcnt[k] + 8'd1;
      mlast[k] = w;
    end
    e.word = mlast[k];
    e.cnt  = mcnt[k];
    if (k == 0) q0.push_back(e);
    else q1.push_back(e);
    send_bit(k, 1'b0, gmax);
    for (int i = 10; i >= 0; i--) send_bit(k, w[i], gmax);
    if (pen) send_bit(k, p, gmax);
    send_bit(k, stopb, gmax);
  endtask

  task automatic drain(input int k);
    @(negedge clk);
    bvv[k] = 1'b0;
    for (int i = 0; i < 30 && qsize(k) != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("drain", k, qsize(k), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    bvv = 2'b00;
    for (int k = 0; k < 2; k++) begin
      mlast[k] = '0;
      mcnt[k]  = '0;
    end
    q0.delete();
    q1.delete();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_in", k, {21'd0, inw[k]}, 0);
      chk("rst_en", k, {31'd0, en[k]}, 0);
      chk("rst_err", k, {31'd0, err[k]}, 0);
      chk("rst_cnt", k, {24'd0, cntw[k]}, 0);
    end
    rst = 1'b0;
  endtask

  initial begin
    int base;
    for (int k = 0; k < 2; k++) begin
      encnt[k]   = 0;
      prev_in[k] = '0;
    end
    repeat (3) @(negedge clk);
    do_reset();
    for (int k = 0; k < 2; k++) begin
      send_frame(k, 11'h700, 1'b0, 1'b1, 0);
      drain(k);
      chk("h700_in", k, {21'd0, inw[k]}, 32'h700);
      chk("h700_cnt", k, {24'd0, cntw[k]}, 1);
      send_frame(k, 11'h700, 1'b1, 1'b1, 0);
      send_frame(k, 11'h0A5, 1'b0, 1'b0, 0);
      send_frame(k, 11'h3FF, 1'b0, 1'b1, 5);
      drain(k);
      chk("h3ff_in", k, {21'd0, inw[k]}, 32'h3FF);
      send_bit(k, 1'b0, 0);
      for (int i = 0; i < 6; i++) send_bit(k, 1'($urandom), 0);
      do_reset();
      send_frame(k, 11'h123, 1'b0, 1'b1, 0);
      drain(k);
      chk("h123_in", k, {21'd0, inw[k]}, 32'h123);
      chk("h123_cnt", k, {24'd0, cntw[k]}, 1);
      for (int i = 0; i < 30; i++) begin
        if ($urandom_range(0, 3) == 0) send_bit(k, 1'b1, 1);
        send_frame(k, 11'($urandom), $urandom_range(0, 3) == 0,
                   $urandom_range(0, 4) != 0, 3);
      end
      drain(k);
      do_reset();
      base = encnt[k];
      for (int i = 0; i < 256; i++)
        send_frame(k, 11'($urandom), 1'b0, 1'b1, 0);
      drain(k);
      chk("wrap_en", k, encnt[k] - base, 256);
      chk("wrap_cnt", k, {24'd0, cntw[k]}, 0);
    end
    for (int k = 0; k < 2; k++)
      chk("final_cnt", k, {24'd0, cntw[k]}, {24'd0, mcnt[k]});
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
